// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file boot loader.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/regfile_loader.sv
// Register-file boot loader: after a start request, writes registers
// FIRST_REG..LAST_REG in ascending order from a valid/ready word stream,
// driving the RF write port with an active-low write strobe. The core is
// held off through busy until the last register has been written.
// Optional feature macro: REGFILE_LOADER_VERIFY_EN adds a readback compare
// of every write with a sticky error flag.
module regfile_loader
  import regfile_pkg::*;
#(
  parameter int XLEN      = regfile_pkg::XLEN,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_data,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_writeAddr,
  output logic [XLEN-1:0]       rf_writeData,
  output logic [REG_ADDR_W-1:0] rf_readAddr,
  input  logic [XLEN-1:0]       rf_readData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // x0 is hard-wired in the RF, so the first loaded register is at least x1,
  // and the last one is kept inside [first, NUM_REGS-1].
  localparam int FIRST_EFF = (FIRST_REG < 1) ? 1 :
                             (FIRST_REG > NUM_REGS - 1) ? NUM_REGS - 1 : FIRST_REG;
  localparam int LAST_EFF  = (LAST_REG < FIRST_EFF) ? FIRST_EFF :
                             (LAST_REG > NUM_REGS - 1) ? NUM_REGS - 1 : LAST_REG;

  localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = REG_ADDR_W'(FIRST_EFF);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = REG_ADDR_W'(LAST_EFF);

  ldr_state_t            state;
  ldr_state_t            state_next;
  logic [REG_ADDR_W-1:0] addr;
  logic                  accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: start only matters in IDLE, the last accept ends LOAD.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept && (addr == LAST_ADDR)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address counter and RF write-port registers: each accept launches a
  // one-cycle write whose strobe is low until the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr            <= FIRST_ADDR;
      rf_write_enable <= 1'b1;
      rf_writeAddr    <= '0;
      rf_writeData    <= '0;
    end else begin
      rf_write_enable <= ~accept;
      if (accept) begin
        rf_writeAddr <= addr;
        rf_writeData <= in_data;
        // Hold at the last register rather than wrapping toward x0.
        if (addr != LAST_ADDR) begin
          addr <= addr + REG_ADDR_W'(1);
        end
      end else if (state == DONE) begin
        addr <= FIRST_ADDR;
      end
    end
  end

`ifdef REGFILE_LOADER_VERIFY_EN
  assign rf_readAddr = rf_writeAddr;

  // Readback compare at the end of each write cycle; the flag stays set
  // until reset while the load carries on.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (!rf_write_enable && (rf_readData != rf_writeData)) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_read;

  assign rf_readAddr = '0;
  assign error       = 1'b0;
  assign unused_read = ^rf_readData;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: a default instance (x1..x31) and a
// narrow instance (x5..x7), each writing a behavioural RF model that
// captures on the negedge while the active-low strobe is asserted.
module tb_regfile_loader;
  import regfile_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data  = '0;
  logic        corrupt  = 1'b0;
  logic        in_ready, we, busy, done, error;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata, rdata;
  logic [31:0] rf [32];

  logic        start3 = 1'b0;
  logic        valid3 = 1'b0;
  logic [31:0] data3  = '0;
  logic        ready3, we3, busy3, done3, error3;
  logic [4:0]  waddr3, raddr3;
  logic [31:0] wdata3, rdata3;
  logic [31:0] rf3 [32];

  int checks = 0;
  int failures = 0;
  int we_low_cnt = 0;
  int done_cnt = 0;
  int run_len = 0;
  int max_run = 0;

  regfile_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rf_write_enable(we),
    .rf_writeAddr(waddr), .rf_writeData(wdata), .rf_readAddr(raddr),
    .rf_readData(rdata), .busy(busy), .done(done), .error(error)
  );

  regfile_loader #(.FIRST_REG(5), .LAST_REG(7)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .in_valid(valid3),
    .in_ready(ready3), .in_data(data3), .rf_write_enable(we3),
    .rf_writeAddr(waddr3), .rf_writeData(wdata3), .rf_readAddr(raddr3),
    .rf_readData(rdata3), .busy(busy3), .done(done3), .error(error3)
  );

  // Register-file models: write on negedge, combinational read.
  assign rdata  = corrupt ? 32'hDEAD_BEEF : rf[raddr];
  assign rdata3 = rf3[raddr3];

  always @(negedge clk) begin
    if (we === 1'b0) rf[waddr] = wdata;
    if (we3 === 1'b0) rf3[waddr3] = wdata3;
    if (we === 1'b0) begin
      we_low_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    start3 = 1'b0; valid3 = 1'b0; corrupt = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_rf();
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      rf3[i] = '0;
    end
  endtask

  task automatic start_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0, k, c;

    // 1: reset state, then a back-to-back load of x1..x31.
    clear_rf();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_we", we, 1);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_raddr", raddr, 0);
    check("rst_error", error, 0);
    start_load();
    check("s1_busy", busy, 1);
    check("s1_ready", in_ready, 1);
    w0 = we_low_cnt; d0 = done_cnt; max_run = 0;
    in_valid = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      in_data = BASE + i;
      step();
      if (i == 1) begin
        check("s1_first_addr", waddr, 1);
        check("s1_first_data", wdata, BASE + 1);
        check("s1_first_we", we, 0);
      end
    end
    check("s1_done", done, 1);
    check("s1_busy_done", busy, 0);
    check("s1_ready_done", in_ready, 0);
    in_valid = 1'b0;
    step();
    check("s1_done_pulse", done, 0);
    check("s1_idle_we", we, 1);
    step();
    for (int i = 1; i <= 31; i++) check($sformatf("s1_rf_x%0d", i), rf[i], BASE + i);
    check("s1_rf_x0", rf[0], 0);
    check("s1_we_cycles", we_low_cnt - w0, 31);
    check("s1_we_run", max_run, 31);
    check("s1_done_cnt", done_cnt - d0, 1);

    // 2: in_valid alternating; strobe low only after accepts.
    clear_rf();
    do_reset();
    start_load();
    k = 1; c = 0;
    while (k <= 31 && c < 200) begin
      in_valid = (c % 2 == 0);
      in_data  = BASE + k;
      step();
      if (in_valid) begin
        check($sformatf("s2_we_acc%0d", k), we, 0);
        check($sformatf("s2_addr%0d", k), waddr, k);
        k++;
      end else begin
        check($sformatf("s2_we_gap%0d", k), we, 1);
        check($sformatf("s2_hold%0d", k), waddr, k - 1);
      end
      c++;
    end
    in_valid = 1'b0;
    check("s2_accepts", k, 32);
    check("s2_done", done, 1);
    step();
    step();
    for (int i = 1; i <= 31; i++) check($sformatf("s2_rf_x%0d", i), rf[i], BASE + i);
    check("s2_rf_x0", rf[0], 0);

    // 3: narrow window x5..x7; 4th word refused; start during DONE ignored.
    clear_rf();
    do_reset();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("s3_ready", ready3, 1);
    valid3 = 1'b1;
    data3 = 32'hA;
    step();
    check("s3_first_addr", waddr3, 5);
    check("s3_first_we", we3, 0);
    data3 = 32'hB;
    step();
    data3 = 32'hC;
    step();
    check("s3_done", done3, 1);
    check("s3_ready_drop", ready3, 0);
    data3 = 32'hD;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("s3_no_accept_we", we3, 1);
    check("s3_idle_busy", busy3, 0);
    check("s3_idle_ready", ready3, 0);
    step();
    check("s3_no_accept_we2", we3, 1);
    valid3 = 1'b0;
    step();
    check("s3_x5", rf3[5], 32'hA);
    check("s3_x6", rf3[6], 32'hB);
    check("s3_x7", rf3[7], 32'hC);
    check("s3_x8", rf3[8], 0);
    check("s3_x4", rf3[4], 0);
    check("s3_last_addr", waddr3, 7);
    check("s3_last_data", wdata3, 32'hC);

    // 4: reset after 10 accepts aborts; restart begins at x1.
    clear_rf();
    do_reset();
    rf[11] = 32'h5555_5555;
    start_load();
    in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = BASE + i;
      step();
    end
    in_data = BASE + 11;
    reset = 1'b1;
    step();
    check("s4_busy", busy, 0);
    check("s4_we", we, 1);
    check("s4_ready", in_ready, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    check("s4_x1", rf[1], BASE + 1);
    check("s4_x10", rf[10], BASE + 10);
    check("s4_x11", rf[11], 32'h5555_5555);
    start_load();
    in_valid = 1'b1;
    in_data = 32'h77;
    step();
    in_valid = 1'b0;
    check("s4_restart_addr", waddr, 1);
    check("s4_restart_we", we, 0);
    step();
    check("s4_restart_x1", rf[1], 32'h77);

    // 5: in_valid in IDLE ignored; start during LOAD ignored.
    clear_rf();
    do_reset();
    w0 = we_low_cnt;
    in_valid = 1'b1;
    in_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s5_idle_busy%0d", i), busy, 0);
      check($sformatf("s5_idle_we%0d", i), we, 1);
    end
    in_valid = 1'b0;
    check("s5_no_writes", we_low_cnt - w0, 0);
    start_load();
    in_valid = 1'b1;
    in_data = BASE + 1;
    step();
    in_data = BASE + 2;
    step();
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s5_busy", busy, 1);
    check("s5_we_gap", we, 1);
    in_valid = 1'b1;
    in_data = BASE + 3;
    step();
    in_valid = 1'b0;
    check("s5_addr", waddr, 3);
    step();
    check("s5_x3", rf[3], BASE + 3);
    check("s5_x4", rf[4], 0);

    // 6: readback compare with a corrupted read during the x3 write.
    clear_rf();
    do_reset();
    start_load();
    in_valid = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      in_data = BASE + i;
      step();
      corrupt = (i == 3);
`ifdef REGFILE_LOADER_VERIFY_EN
      if (i == 2) check("s6_raddr", raddr, 2);
      if (i == 3) check("s6_err_before", error, 0);
      if (i == 4) check("s6_err_set", error, 1);
`else
      if (i == 3) check("s6_raddr_tied", raddr, 0);
      if (i == 4) check("s6_err_tied", error, 0);
`endif
    end
    in_valid = 1'b0;
    corrupt = 1'b0;
    check("s6_done", done, 1);
`ifdef REGFILE_LOADER_VERIFY_EN
    check("s6_err_done", error, 1);
    step();
    step();
    check("s6_err_sticky", error, 1);
`else
    check("s6_err_done_tied", error, 0);
    step();
    step();
`endif
    check("s6_x31", rf[31], BASE + 31);
    do_reset();
    check("s6_err_reset", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
